btb_set_assoc: RTL

- Parametrised N-way set-associative Branch Target Buffer with configurable-width saturating direction counters, sitting in the IF-stage branch prediction path.
- Lookup is combinational from the fetch PC; updates arrive synchronously from EX on branch/jump resolution.
- New relative to the direct-mapped predictor:
  - associativity with round-robin replacement;
  - allocation only on taken outcomes;
  - a multi-cycle flush engine (for fence.i / context change) with a busy indication.

---
 rtl/btb_set_assoc.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/btb_set_assoc.sv
// btb_set_assoc: N-way set-associative branch target buffer.
//
// Provides a combinational prediction from the fetch PC and accepts
// synchronous resolution updates from EX. Each entry holds a valid bit,
// a tag, a branch target and a saturating direction counter. Entries are
// allocated only on taken outcomes; replacement is round-robin per set.
// A multi-cycle flush engine invalidates one set per cycle.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_pc                 fetch PC for lookup
//   o_btb_hit            valid tag match in the indexed set
//   o_predicted_taken    hit and counter MSB set
//   o_predicted_target   target of the hitting way, 0 on miss
//   i_update*            resolution update (pc, target, outcome)
//   i_flush              start invalidation of all entries
//   o_flush_busy         flush engine active
//
// Flush FSM states:
//   state    | meaning
//   ST_IDLE  | lookups and updates serviced normally
//   ST_FLUSH | one set invalidated per cycle; lookups miss, updates dropped

module btb_set_assoc #(
    parameter int XLEN           = 32,
    parameter int BTB_INDEX_BITS = 4,
    parameter int BTB_WAYS       = 2,
    parameter int CTR_BITS       = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_btb_hit,
    output logic            o_predicted_taken,
    output logic [XLEN-1:0] o_predicted_target,
    input  logic            i_update,
    input  logic [XLEN-1:0] i_update_pc,
    input  logic [XLEN-1:0] i_update_target,
    input  logic            i_update_taken,
    input  logic            i_flush,
    output logic            o_flush_busy
);

    localparam int SETS  = 1 << BTB_INDEX_BITS;
    localparam int TAG_W = XLEN - BTB_INDEX_BITS - 1;
    localparam int WAY_W = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    function automatic logic [BTB_INDEX_BITS-1:0] idx_of(input logic [XLEN-1:0] pc);
        return pc[BTB_INDEX_BITS+1:2];
    endfunction

    // pc[1] is folded into the tag so compressed half-word branches in the
    // same word do not alias.
    function automatic logic [TAG_W-1:0] tag_of(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:BTB_INDEX_BITS+2], pc[1]};
    endfunction

    logic                valid_q  [SETS][BTB_WAYS];
    logic                valid_d  [SETS][BTB_WAYS];
    logic [TAG_W-1:0]    tag_q    [SETS][BTB_WAYS];
    logic [TAG_W-1:0]    tag_d    [SETS][BTB_WAYS];
    logic [XLEN-1:0]     target_q [SETS][BTB_WAYS];
    logic [XLEN-1:0]     target_d [SETS][BTB_WAYS];
    logic [CTR_BITS-1:0] ctr_q    [SETS][BTB_WAYS];
    logic [CTR_BITS-1:0] ctr_d    [SETS][BTB_WAYS];
    logic [WAY_W-1:0]    victim_q [SETS];
    logic [WAY_W-1:0]    victim_d [SETS];

    state_t                    state_q, state_d;
    logic [BTB_INDEX_BITS-1:0] flush_set_q, flush_set_d;
    logic                      flush_busy_q, flush_busy_d;

    logic unused_pc_bit0;
    assign unused_pc_bit0 = i_pc[0] ^ i_update_pc[0];

    // ---------------- lookup ----------------
    logic [BTB_INDEX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]          lk_tag;
    logic                      lk_hit;
    logic                      lk_msb;
    logic [XLEN-1:0]           lk_target;

    always_comb begin
        lk_idx    = idx_of(i_pc);
        lk_tag    = tag_of(i_pc);
        lk_hit    = 1'b0;
        lk_msb    = 1'b0;
        lk_target = '0;
        for (int w = 0; w < BTB_WAYS; w++) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                lk_hit    = 1'b1;
                lk_msb    = ctr_q[lk_idx][w][CTR_BITS-1];
                lk_target = target_q[lk_idx][w];
            end
        end
    end

    // Reset gating keeps the outputs quiet during the reset cycle itself,
    // before the valid bits have actually been cleared.
    assign o_btb_hit          = lk_hit & ~flush_busy_q & ~i_rst;
    assign o_predicted_taken  = o_btb_hit & lk_msb;
    assign o_predicted_target = o_btb_hit ? lk_target : '0;
    assign o_flush_busy       = flush_busy_q;

    // ---------------- update-side match ----------------
    logic [BTB_INDEX_BITS-1:0] u_idx;
    logic [TAG_W-1:0]          u_tag;
    logic                      u_hit;
    logic [WAY_W-1:0]          u_way;
    logic                      free_found;
    logic [WAY_W-1:0]          free_way;

    always_comb begin
        u_idx      = idx_of(i_update_pc);
        u_tag      = tag_of(i_update_pc);
        u_hit      = 1'b0;
        u_way      = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < BTB_WAYS; w++) begin
            if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
            end
            if (!valid_q[u_idx][w] && !free_found) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
    end

    // ---------------- next state ----------------
    logic [WAY_W-1:0] alloc_way;

    always_comb begin
        valid_d     = valid_q;
        tag_d       = tag_q;
        target_d    = target_q;
        ctr_d       = ctr_q;
        victim_d    = victim_q;
        state_d     = state_q;
        flush_set_d = flush_set_q;
        alloc_way   = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_flush) begin
                    state_d     = ST_FLUSH;
                    flush_set_d = '0;
                end else if (i_update) begin
                    if (u_hit) begin
                        if (i_update_taken) begin
                            if (ctr_q[u_idx][u_way] != CTR_MAX)
                                ctr_d[u_idx][u_way] = ctr_q[u_idx][u_way] + 1'b1;
                            target_d[u_idx][u_way] = i_update_target;
                        end else if (ctr_q[u_idx][u_way] != '0) begin
                            ctr_d[u_idx][u_way] = ctr_q[u_idx][u_way] - 1'b1;
                        end
                    end else if (i_update_taken) begin
                        // Invalid ways are consumed first and leave the
                        // round-robin pointer untouched.
                        if (free_found) begin
                            alloc_way = free_way;
                        end else begin
                            alloc_way = victim_q[u_idx];
                            if (BTB_WAYS > 1)
                                victim_d[u_idx] = victim_q[u_idx] + 1'b1;
                        end
                        valid_d[u_idx][alloc_way]  = 1'b1;
                        tag_d[u_idx][alloc_way]    = u_tag;
                        target_d[u_idx][alloc_way] = i_update_target;
                        ctr_d[u_idx][alloc_way]    = CTR_INIT;
                    end
                end
            end
            ST_FLUSH: begin
                for (int w = 0; w < BTB_WAYS; w++)
                    valid_d[flush_set_q][w] = 1'b0;
                if (flush_set_q == '1) begin
                    state_d     = ST_IDLE;
                    flush_set_d = '0;
                end else begin
                    flush_set_d = flush_set_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        flush_busy_d = (state_d == ST_FLUSH);
    end

    // ---------------- state registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < BTB_WAYS; w++)
                    valid_q[s][w] <= 1'b0;
                victim_q[s] <= '0;
            end
            state_q      <= ST_IDLE;
            flush_set_q  <= '0;
            flush_busy_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            victim_q     <= victim_d;
            state_q      <= state_d;
            flush_set_q  <= flush_set_d;
            flush_busy_q <= flush_busy_d;
        end
    end

    // Payload is meaningless while invalid, so it carries no reset.
    always_ff @(posedge i_clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
    end

endmodule
